pc_fetch_ctrl: RTL and testbench

//  Sequencer for the 16-bit PC register of the single-cycle CPU. Drives the PC's
//  in/wen pins, runs a req/ack handshake with instruction memory, selects next-PC
//  (sequential, branch, jump), and handles stall and halt. Sits between decode/

---
 rtl/pc_fetch_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//   Sequencer for the 16-bit PC register of the single-cycle CPU. It issues
//   the instruction fetch request, waits for the memory handshake, presents
//   the fetched instruction to decode for one cycle, and then selects and
//   writes the next PC. The next-PC source is chosen by this priority:
//   halt > stall > jump > branch > sequential. It also counts the PC updates
//   it performs.
//
// Parameters
//   PC_STEP   sequential increment in bytes (default 2)
//   TRAP_VEC  redirect address used for a misaligned target (trap build only)
//
// Build option
//   MISALIGN_TRAP_EN  When defined, a jump or branch target with bit0=1 is
//                     replaced by TRAP_VEC and trap pulses. When undefined,
//                     target bit0 is cleared and trap is tied to 0.
//
// Ports
//   clk           in   rising-edge system clock
//   rst           in   asynchronous active-low reset
//   pc_cur        in   current PC (PC register output)
//   pc_next       out  next PC (PC register input), combinational
//   pc_wen        out  PC register write enable
//   imem_req      out  instruction fetch request
//   imem_addr     out  fetch address, always equal to pc_cur
//   imem_ack      in   memory ready; only sampled while imem_req=1
//   instr_valid   out  one-cycle pulse on entry to execute
//   branch_taken  in   conditional branch resolved taken
//   branch_target in   branch destination
//   jump          in   unconditional jump
//   jump_target   in   jump destination
//   stall         in   hazard hold: keep the current PC
//   halt          in   halt instruction decoded
//   halted        out  controller is halted (cleared only by reset)
//   trap          out  one-cycle pulse when a misaligned redirect is trapped
//   fetch_count   out  number of PC updates, saturating at 16'hFFFF
module pc_fetch_ctrl #(
  parameter logic [15:0] PC_STEP  = 16'd2,
  parameter logic [15:0] TRAP_VEC = 16'h0002
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc_cur,
  output logic [15:0] pc_next,
  output logic        pc_wen,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  output logic        instr_valid,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic        jump,
  input  logic [15:0] jump_target,
  input  logic        stall,
  input  logic        halt,
  output logic        halted,
  output logic        trap,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_EXEC   = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        exec_first;
  logic [15:0] fetch_cnt_q;

  logic        redirect;
  logic [15:0] raw_target;
  logic [15:0] redir_pc;
  logic        misaligned;
  logic        advance;

  // Redirect target selection. Jump wins over branch.
  always_comb begin
    redirect   = jump | branch_taken;
    raw_target = jump ? jump_target : branch_target;
`ifdef MISALIGN_TRAP_EN
    misaligned = redirect & raw_target[0];
    redir_pc   = misaligned ? TRAP_VEC : raw_target;
`else
    misaligned = 1'b0;
    redir_pc   = raw_target & ~16'h0001;
`endif
  end

  // pc_next is valid in every state; the PC register only consumes it
  // while pc_wen is high. The sequential add wraps modulo 2^16.
  always_comb begin
    pc_next = redirect ? redir_pc : (pc_cur + PC_STEP);
  end

  assign imem_addr   = pc_cur;
  assign fetch_count = fetch_cnt_q;

  // The PC advances in execute unless halt or stall holds it.
  assign advance = (state == S_EXEC) && !halt && !stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Marks the first execute cycle, so that instr_valid does not repeat
  // while a stall holds the controller in execute.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exec_first <= 1'b0;
    end else begin
      exec_first <= (state == S_REQ) && imem_ack;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
    end else if (advance && (fetch_cnt_q != '1)) begin
      fetch_cnt_q <= fetch_cnt_q + 16'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    pc_wen      = 1'b0;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    trap        = 1'b0;
    unique case (state)
      S_IDLE: begin
        state_nxt = S_REQ;
      end
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        instr_valid = exec_first;
        if (halt) begin
          state_nxt = S_HALTED;
        end else if (stall) begin
          state_nxt = S_EXEC;
        end else begin
          pc_wen    = 1'b1;
          trap      = misaligned;
          state_nxt = S_REQ;
        end
      end
      S_HALTED: begin
        halted    = 1'b1;
        state_nxt = S_HALTED;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
module tb_pc_fetch_ctrl;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif
  localparam logic [15:0] TRAP_VEC = 16'h0002;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] pc_q;
  logic [15:0] pc_next;
  logic        pc_wen;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic        instr_valid;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [15:0] jump_target = '0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        halted;
  logic        trap;
  logic [15:0] fetch_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.PC_STEP(16'd2), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc_q), .pc_next(pc_next), .pc_wen(pc_wen),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .instr_valid(instr_valid), .branch_taken(branch_taken),
    .branch_target(branch_target), .jump(jump), .jump_target(jump_target),
    .stall(stall), .halt(halt), .halted(halted), .trap(trap),
    .fetch_count(fetch_count)
  );

  // The PC register the controller sequences; it shares the reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= '0;
    else if (pc_wen) pc_q <= pc_next;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase of the fetch/execute cycle as seen from outside the controller.
  typedef enum int {PH_IDLE, PH_FETCH, PH_RUN, PH_STOP} phase_t;
  phase_t      m_phase;
  bit          m_fresh;     // instruction just delivered, not yet announced
  int unsigned m_updates;   // PC writes since reset
  logic [15:0] e_next;
  bit          e_req, e_wen, e_iv, e_halted, e_trap;

  task automatic model_reset();
    m_phase   = PH_IDLE;
    m_fresh   = 0;
    m_updates = 0;
  endtask

  task automatic model_eval();
    int unsigned tgt;
    bit redir;
    redir = jump || branch_taken;
    tgt   = jump ? jump_target : (branch_taken ? branch_target : (pc_q + 2) % 65536);
    e_trap = 0;
    if (redir && (tgt % 2 == 1)) begin
      if (TRAP_EN) tgt = TRAP_VEC;
      else tgt = tgt - 1;
    end
    e_next   = 16'(tgt);
    e_req    = (m_phase == PH_FETCH);
    e_iv     = (m_phase == PH_RUN) && m_fresh;
    e_wen    = (m_phase == PH_RUN) && !halt && !stall;
    e_halted = (m_phase == PH_STOP);
    e_trap   = TRAP_EN && e_wen && redir && ((jump ? jump_target[0] : branch_target[0]) == 1'b1);
  endtask

  task automatic model_step();
    case (m_phase)
      PH_IDLE:  m_phase = PH_FETCH;
      PH_FETCH: if (imem_ack) begin m_phase = PH_RUN; m_fresh = 1; end
      PH_RUN: begin
        m_fresh = 0;
        if (halt) m_phase = PH_STOP;
        else if (!stall) begin
          m_phase = PH_FETCH;
          if (m_updates < 65535) m_updates++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".imem_req"},    16'(imem_req),    16'(e_req));
    check({tag, ".pc_wen"},      16'(pc_wen),      16'(e_wen));
    check({tag, ".instr_valid"}, 16'(instr_valid), 16'(e_iv));
    check({tag, ".halted"},      16'(halted),      16'(e_halted));
    check({tag, ".trap"},        16'(trap),        16'(e_trap));
    check({tag, ".pc_next"},     pc_next,          e_next);
    check({tag, ".imem_addr"},   imem_addr,        pc_q);
    check({tag, ".fetch_count"}, fetch_count,      16'(m_updates));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    {imem_ack, stall, halt, jump, branch_taken} = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        ack, stl, hlt, jmp, br;
    logic [15:0] jt, bt;
    logic        req, wen, iv, hd, trp;
    logic [15:0] nxt, cnt;
  } vec_t;

  vec_t tbl[22];

  initial begin
    logic [15:0] misal_next, after_next;
    misal_next = TRAP_EN ? 16'h0002 : 16'h0100;
    after_next = TRAP_EN ? 16'h0004 : 16'h0102;
    //           ack stl hlt jmp br  jt        bt        req wen iv hd trp nxt         cnt
    tbl[0]  = '{1, 0, 0, 0, 0, 16'h0, 16'h0,       0, 0, 0, 0, 0, 16'h0002, 16'd0};
    tbl[1]  = '{1, 0, 0, 0, 0, 16'h0, 16'h0,       1, 0, 0, 0, 0, 16'h0002, 16'd0};
    tbl[2]  = '{1, 0, 0, 0, 0, 16'h0, 16'h0,       0, 1, 1, 0, 0, 16'h0002, 16'd0};
    tbl[3]  = '{1, 0, 0, 0, 0, 16'h0, 16'h0,       1, 0, 0, 0, 0, 16'h0004, 16'd1};
    tbl[4]  = '{1, 0, 0, 0, 0, 16'h0, 16'h0,       0, 1, 1, 0, 0, 16'h0004, 16'd1};
    tbl[5]  = '{1, 0, 0, 0, 0, 16'h0, 16'h0,       1, 0, 0, 0, 0, 16'h0006, 16'd2};
    tbl[6]  = '{1, 0, 0, 0, 0, 16'h0, 16'h0,       0, 1, 1, 0, 0, 16'h0006, 16'd2};
    tbl[7]  = '{0, 0, 0, 0, 0, 16'h0, 16'h0,       1, 0, 0, 0, 0, 16'h0008, 16'd3};
    tbl[8]  = '{0, 0, 0, 0, 0, 16'h0, 16'h0,       1, 0, 0, 0, 0, 16'h0008, 16'd3};
    tbl[9]  = '{0, 0, 0, 0, 0, 16'h0, 16'h0,       1, 0, 0, 0, 0, 16'h0008, 16'd3};
    tbl[10] = '{1, 0, 0, 0, 0, 16'h0, 16'h0,       1, 0, 0, 0, 0, 16'h0008, 16'd3};
    tbl[11] = '{0, 1, 0, 1, 1, 16'h0100, 16'h0200, 0, 0, 1, 0, 0, 16'h0100, 16'd3};
    tbl[12] = '{0, 0, 0, 1, 1, 16'h0100, 16'h0200, 0, 1, 0, 0, 0, 16'h0100, 16'd3};
    tbl[13] = '{1, 0, 0, 1, 0, 16'hFFFE, 16'h0,    1, 0, 0, 0, 0, 16'hFFFE, 16'd4};
    tbl[14] = '{0, 0, 0, 1, 0, 16'hFFFE, 16'h0,    0, 1, 1, 0, 0, 16'hFFFE, 16'd4};
    tbl[15] = '{1, 0, 0, 0, 0, 16'h0, 16'h0,       1, 0, 0, 0, 0, 16'h0000, 16'd5};
    tbl[16] = '{0, 0, 0, 0, 0, 16'h0, 16'h0,       0, 1, 1, 0, 0, 16'h0000, 16'd5};
    tbl[17] = '{1, 0, 0, 0, 0, 16'h0, 16'h0,       1, 0, 0, 0, 0, 16'h0002, 16'd6};
    tbl[18] = '{0, 0, 0, 0, 1, 16'h0, 16'h0101,    0, 1, 1, 0, TRAP_EN, misal_next, 16'd6};
    tbl[19] = '{1, 0, 0, 0, 0, 16'h0, 16'h0,       1, 0, 0, 0, 0, after_next, 16'd7};
    tbl[20] = '{0, 0, 1, 0, 0, 16'h0, 16'h0,       0, 0, 1, 0, 0, after_next, 16'd7};
    tbl[21] = '{1, 0, 0, 0, 0, 16'h0, 16'h0,       0, 0, 0, 1, 0, after_next, 16'd7};

    do_reset();
    // Reset state (IDLE, inputs quiet)
    #1;
    check("rst.pc_wen", 16'(pc_wen), 16'd0);
    check("rst.imem_req", 16'(imem_req), 16'd0);
    check("rst.fetch_count", fetch_count, 16'd0);

    for (int i = 0; i < 22; i++) begin
      if (i > 0) @(negedge clk);
      imem_ack = tbl[i].ack; stall = tbl[i].stl; halt = tbl[i].hlt;
      jump = tbl[i].jmp; branch_taken = tbl[i].br;
      jump_target = tbl[i].jt; branch_target = tbl[i].bt;
      #1;
      check($sformatf("vec%0d.imem_req", i),    16'(imem_req),    16'(tbl[i].req));
      check($sformatf("vec%0d.pc_wen", i),      16'(pc_wen),      16'(tbl[i].wen));
      check($sformatf("vec%0d.instr_valid", i), 16'(instr_valid), 16'(tbl[i].iv));
      check($sformatf("vec%0d.halted", i),      16'(halted),      16'(tbl[i].hd));
      check($sformatf("vec%0d.trap", i),        16'(trap),        16'(tbl[i].trp));
      check($sformatf("vec%0d.pc_next", i),     pc_next,          tbl[i].nxt);
      check($sformatf("vec%0d.fetch_count", i), fetch_count,      tbl[i].cnt);
    end

    // Halted stays put for 20 cycles whatever the inputs do.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      imem_ack = 1'($urandom); jump = 1'($urandom); stall = 1'($urandom);
      #1;
      check("halt_hold.halted", 16'(halted), 16'd1);
      check("halt_hold.pc_wen", 16'(pc_wen), 16'd0);
      check("halt_hold.imem_req", 16'(imem_req), 16'd0);
    end

    // Reset asserted mid-REQ: outputs clear at once.
    do_reset();
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("midreq.imem_req_before", 16'(imem_req), 16'd1);
    rst = 1'b0;
    #1;
    check("midreq.imem_req", 16'(imem_req), 16'd0);
    check("midreq.pc_wen", 16'(pc_wen), 16'd0);
    check("midreq.instr_valid", 16'(instr_valid), 16'd0);
    check("midreq.halted", 16'(halted), 16'd0);
    check("midreq.fetch_count", fetch_count, 16'd0);

    // Reset asserted mid-EXEC: no PC write.
    do_reset();
    imem_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("midexec.pc_wen_before", 16'(pc_wen), 16'd1);
    rst = 1'b0;
    #1;
    check("midexec.pc_wen", 16'(pc_wen), 16'd0);
    check("midexec.instr_valid", 16'(instr_valid), 16'd0);
    check("midexec.pc", pc_q, 16'd0);

    // Randomized traffic against the reference model.
    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        if (c > 0) @(negedge clk);
        imem_ack      = ($urandom_range(0, 2) != 0);
        stall         = ($urandom_range(0, 3) == 0);
        halt          = ($urandom_range(0, 119) == 0);
        jump          = ($urandom_range(0, 4) == 0);
        branch_taken  = ($urandom_range(0, 3) == 0);
        jump_target   = 16'($urandom) & ~16'(($urandom_range(0, 3) != 0));
        branch_target = 16'($urandom) & ~16'(($urandom_range(0, 3) != 0));
        model_eval();
        #1;
        check_all($sformatf("rnd%0d.%0d", ep, c));
        @(posedge clk);
        model_step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
